// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared definitions for the servo command sequencer:
//   - state_e      : sequencer states (IDLE, MOVE, HOLD, RETURN, MOVE_ONLY)
//   - SEL_*        : position select codes driven to the PWM generator
//   - ms_to_cycles : converts a millisecond interval into clock cycles
// -----------------------------------------------------------------------------
package servo_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE      = 3'd1,
        HOLD      = 3'd2,
        RETURN    = 3'd3,
        MOVE_ONLY = 3'd4
    } state_e;

    localparam logic [1:0] SEL_POS0 = 2'd0;
    localparam logic [1:0] SEL_POS1 = 2'd1;
    localparam logic [1:0] SEL_POS2 = 2'd2;
    localparam logic [1:0] SEL_OFF  = 2'd3;

    // Number of clock cycles spanned by 'ms' milliseconds at 'clk_hz'.
    function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                                 input int unsigned clk_hz);
        return ms * (clk_hz / 32'd1000);
    endfunction

endpackage

// File: rtl/servo_cmd_seq_ms_tick.sv
// -----------------------------------------------------------------------------
// ms_tick
// Millisecond prescaler. Emits a one-cycle tick every CLK_HZ/1000 cycles,
// counted from the last synchronous clear.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   clr   in  synchronous clear of the prescaler (restarts the ms period)
//   tick  out high for one cycle at the end of each millisecond
// -----------------------------------------------------------------------------
module ms_tick
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV  = ms_to_cycles(32'd1, CLK_HZ);
    // A divide-by-one prescaler still needs a one-bit register.
    localparam int unsigned PS_W = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 32'd1);

    logic [PS_W-1:0] r_cnt;

    assign tick = (r_cnt == PS_LAST);

    // Prescaler counter: restarts on clear or at the end of each ms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PS_W'(1);
        end
    end

endmodule

// File: rtl/servo_cmd_seq.sv
// -----------------------------------------------------------------------------
// servo_cmd_seq
// Command sequencer in front of the servo PWM generator. Accepts a position
// command, drives it for MOVE_MS, dwells for HOLD_MS, then returns to
// HOME_POS for MOVE_MS and pulses done. A command equal to HOME_POS only runs
// the MOVE_MS phase; the off code (3) is applied at once with an immediate done.
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   cmd_valid in  command present
//   cmd_pos   in  target select code (0..2 positions, 3 = pulse off)
//   abort     in  (only with SERVO_ABORT_EN) cut MOVE/HOLD short, go home
//   cmd_ready out sequencer can accept a command
//   sel       out position select to the PWM generator
//   busy      out sequence in progress
//   done      out one-cycle pulse when a sequence completes
// Build option: define SERVO_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module servo_cmd_seq
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned MOVE_MS  = 500,
    parameter int unsigned HOLD_MS  = 2000,
    parameter logic [1:0]  HOME_POS = SEL_POS0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_pos,
`ifdef SERVO_ABORT_EN
    input  logic       abort,
`endif
    output logic       cmd_ready,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MAX_MS = (MOVE_MS > HOLD_MS) ? MOVE_MS : HOLD_MS;
    localparam int unsigned MS_W   = $clog2(MAX_MS + 32'd1);
    localparam logic [MS_W-1:0] MOVE_LAST = MS_W'(MOVE_MS - 32'd1);
    localparam logic [MS_W-1:0] HOLD_LAST = MS_W'(HOLD_MS - 32'd1);

    state_e          r_state;
    logic [1:0]      r_target;
    logic [1:0]      r_sel;
    logic            r_cmd_ready;
    logic            r_busy;
    logic            r_done;
    logic [MS_W-1:0] r_ms_cnt;

    logic            w_tick;
    logic            w_accept;
    logic            w_abort;
    logic            w_phase_end;
    logic            w_clr;
    logic [MS_W-1:0] w_last_ms;

    assign cmd_ready = r_cmd_ready;
    assign sel       = r_sel;
    assign busy      = r_busy;
    assign done      = r_done;

    assign w_accept = cmd_valid & r_cmd_ready & (r_state == IDLE);

`ifdef SERVO_ABORT_EN
    assign w_abort = abort & ((r_state == MOVE) | (r_state == HOLD));
`else
    assign w_abort = 1'b0;
`endif

    // Last ms index of the current phase; only HOLD uses HOLD_MS.
    always_comb begin
        w_last_ms = MOVE_LAST;
        case (r_state)
            HOLD:    w_last_ms = HOLD_LAST;
            default: w_last_ms = MOVE_LAST;
        endcase
    end

    assign w_phase_end = w_tick & (r_ms_cnt == w_last_ms) & (r_state != IDLE);
    // Every phase start restarts the prescaler so phase lengths are exact.
    assign w_clr       = w_accept | w_phase_end | w_abort;

    ms_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // Elapsed whole milliseconds within the current phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ms_cnt <= '0;
        end else if (w_clr) begin
            r_ms_cnt <= '0;
        end else if (w_tick && (r_state != IDLE)) begin
            r_ms_cnt <= r_ms_cnt + MS_W'(1);
        end else begin
            r_ms_cnt <= r_ms_cnt;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_target    <= HOME_POS;
            r_sel       <= HOME_POS;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Ready drops in the done cycle and comes back here.
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_target    <= cmd_pos;
                        r_sel       <= cmd_pos;
                        if (cmd_pos == SEL_OFF) begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end else if (cmd_pos == HOME_POS) begin
                            r_busy  <= 1'b1;
                            r_state <= MOVE_ONLY;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= MOVE;
                        end
                    end
                end
                MOVE: begin
                    if (w_abort) begin
                        r_sel   <= HOME_POS;
                        r_state <= RETURN;
                    end else if (w_phase_end) begin
                        r_sel   <= r_target;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_abort || w_phase_end) begin
                        r_sel   <= HOME_POS;
                        r_state <= RETURN;
                    end
                end
                RETURN, MOVE_ONLY: begin
                    if (w_phase_end) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_sel       <= HOME_POS;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
